fc_act_serializer: RTL and testbench
====================================

Name: fc_act_serializer

Overview:
- Sits directly downstream of an FC layer wrapper and feeds the next FC layer.
- Captures the layer's parallel accumulator vector on a single-cycle valid and requantizes each value by an arithmetic right shift, ReLU and saturation.
- Streams the results one element per cycle as the next layer's `valid_in`/`input_data` sequence, with ready backpressure and a last marker.

Parameters:
- NUM_NEURONS, 16, number of accumulators captured per frame (= next layer INPUT chunk length).
- DATA_WIDTH, 16, signed width of each streamed activation.
- ACC_WIDTH, 32, signed width of each incoming accumulator.
- SHIFT, 8, requantization right-shift (fractional bits removed).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  single-cycle pulse; in_data holds a complete frame.
- in_data  in  NUM_NEURONS x ACC_WIDTH signed  accumulator array, unpacked [NUM_NEURONS].
- in_ready  out  1  block can accept a frame this cycle.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts out_data this cycle.
- out_data  out  DATA_WIDTH signed  activation element.
- out_last  out  1  asserted with the element at index NUM_NEURONS-1.
- drop  out  1  one-cycle pulse: in_valid arrived while in_ready=0 and the frame was discarded.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, index=0, out_valid=0, out_last=0, out_data=0, drop=0. Buffer contents are don't-care.
- An assertion of rst_n mid-stream aborts the frame immediately; no partial-frame outputs follow reset release.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - STREAM: out_valid=1, out_data=buf[index], out_last=(index==NUM_NEURONS-1).
- Requantization, applied per element at capture and stored in a registered buffer of NUM_NEURONS x DATA_WIDTH:
  - s = acc >>> SHIFT (arithmetic shift, floor toward -inf).
  - If s<0, result is 0.
  - Else if s > 2^(DATA_WIDTH-1)-1, result is 2^(DATA_WIDTH-1)-1.
  - Else result is s[DATA_WIDTH-1:0].
- IDLE to STREAM: on in_valid && in_ready, capture all elements, set index=0. First out_valid appears the next cycle (latency 1).
- Handshake:
  - An element transfers on out_valid && out_ready.
  - While out_valid && !out_ready, out_data and out_last are held stable.
  - On transfer with index<NUM_NEURONS-1, index increments.
- Last transfer:
  - On transfer with index==NUM_NEURONS-1: if in_valid is also high that cycle, capture the new frame and remain in STREAM with index=0 (back-to-back, no bubble). Otherwise go to IDLE.
  - in_ready = (state==IDLE) || (out_valid && out_ready && out_last). This is combinational from state/index and out_ready.
- Drop: in_valid while in_ready=0 discards the frame. drop pulses the following cycle and the current stream is unaffected.
- Throughput: NUM_NEURONS cycles per frame with out_ready held high.
- NUM_NEURONS=1: every transfer is last, and out_last=1 throughout STREAM.
- index width is $clog2(NUM_NEURONS), minimum 1.

Decomposition:
- Shared package fc_pkg holds:
  - the default widths (DATA_WIDTH, ACC_WIDTH, SHIFT);
  - typedefs acc_t (signed ACC_WIDTH) and act_t (signed DATA_WIDTH);
  - a function requant_relu_sat(acc_t, shift) returning act_t.
- One natural sub-module: act_requant, a purely combinational per-element shift/ReLU/saturate, instantiated NUM_NEURONS times via generate.
- The FSM, buffer and index stay in fc_act_serializer.

Test Plan:
- Basic frame, NUM_NEURONS=4, SHIFT=8, in_data={0x00000300, 0xFFFFFF00, 0x00000080, 0x7FFFFFFF}, out_ready=1 -> out_data 3, 0, 0, 32767 on 4 consecutive cycles. First element 1 cycle after in_valid. out_last only on the 4th.
- Backpressure: same frame, out_ready low for 3 cycles while out_valid and index=1 -> out_data stays 0 (index 1) stable. Stream resumes with 0, 32767, totalling exactly 4 transfers.
- Back-to-back: second in_valid coincident with the last transfer -> in_ready=1 that cycle, next cycle out_data = new frame element 0, no idle bubble, drop=0.
- Overrun: in_valid at index=1 of an active stream -> drop=1 for exactly one cycle. The current frame completes unchanged and the discarded values never appear.
- Reset mid-stream: assert rst_n=0 asynchronously at index=2 -> out_valid, out_last and out_data go to 0 without a clock edge. After release, in_ready=1 and no stale elements are emitted.
- Rounding and saturation edges: acc=-1 gives 0; acc=0x000000FF gives 0; acc=(32767<<8) gives 32767; acc=(32768<<8) gives 32767.

Source files
------------

// File: rtl/fc_pkg.sv
// Shared widths, types and the requantization rule for the FC datapath.
package fc_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int ACC_WIDTH  = 32;
    localparam int SHIFT      = 8;

    typedef logic signed [ACC_WIDTH-1:0]  acc_t;
    typedef logic signed [DATA_WIDTH-1:0] act_t;

    localparam act_t ACT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};

    function automatic act_t requant_relu_sat(acc_t acc, int shift);
        acc_t s;
        s = acc >>> shift;
        if (s[ACC_WIDTH-1]) return '0;
        if (s > acc_t'(ACT_MAX)) return ACT_MAX;
        return s[DATA_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/act_requant.sv
// Per-element requantizer: arithmetic shift, ReLU, saturate to DATA_WIDTH.
module act_requant #(
    parameter int ACC_WIDTH  = fc_pkg::ACC_WIDTH,
    parameter int DATA_WIDTH = fc_pkg::DATA_WIDTH,
    parameter int SHIFT      = fc_pkg::SHIFT
) (
    input  logic signed [ACC_WIDTH-1:0]  acc,
    output logic signed [DATA_WIDTH-1:0] act
);
    import fc_pkg::*;

    localparam logic signed [ACC_WIDTH-1:0] MAX_S =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] MAX_A =
        {1'b0, {(DATA_WIDTH-1){1'b1}}};

    logic signed [ACC_WIDTH-1:0] s;

    assign s = acc >>> SHIFT;

    always_comb begin
        if (s[ACC_WIDTH-1])
            act = '0;
        else if (s > MAX_S)
            act = MAX_A;
        else
            act = s[DATA_WIDTH-1:0];
    end

endmodule

// File: rtl/fc_act_serializer.sv
// Captures an FC accumulator frame, requantizes it and streams it out
// one activation per cycle with valid/ready backpressure.
module fc_act_serializer #(
    parameter int NUM_NEURONS = 16,
    parameter int DATA_WIDTH  = fc_pkg::DATA_WIDTH,
    parameter int ACC_WIDTH   = fc_pkg::ACC_WIDTH,
    parameter int SHIFT       = fc_pkg::SHIFT
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    input  logic signed [ACC_WIDTH-1:0]  in_data [NUM_NEURONS],
    output logic                         in_ready,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic                         out_last,
    output logic                         drop
);
    import fc_pkg::*;

    localparam int IW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_NEURONS - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t state, state_nx;
    logic [IW-1:0] index, index_nx;
    logic signed [DATA_WIDTH-1:0] act_buf [NUM_NEURONS];
    logic signed [DATA_WIDTH-1:0] requant [NUM_NEURONS];
    logic is_last, xfer, capture;

    for (genvar i = 0; i < NUM_NEURONS; i++) begin : g_rq
        act_requant #(
            .ACC_WIDTH (ACC_WIDTH),
            .DATA_WIDTH(DATA_WIDTH),
            .SHIFT     (SHIFT)
        ) u_rq (
            .acc(in_data[i]),
            .act(requant[i])
        );
    end

    // Outputs decode straight from state so an async reset clears them at once.
    assign out_valid = (state == STREAM);
    assign is_last   = (index == LAST_IDX);
    assign out_last  = out_valid && is_last;
    assign out_data  = out_valid ? act_buf[index] : '0;
    assign xfer      = out_valid && out_ready;
    assign in_ready  = (state == IDLE) || (xfer && is_last);
    assign capture   = in_valid && in_ready;

    always_comb begin
        state_nx = state;
        index_nx = index;
        case (state)
            IDLE: begin
                if (capture) begin
                    state_nx = STREAM;
                    index_nx = '0;
                end
            end
            STREAM: begin
                if (xfer) begin
                    if (is_last) begin
                        index_nx = '0;
                        state_nx = capture ? STREAM : IDLE;
                    end else begin
                        index_nx = index + IW'(1);
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            index <= '0;
            drop  <= 1'b0;
        end else begin
            state <= state_nx;
            index <= index_nx;
            drop  <= in_valid && !in_ready;
        end
    end

    always_ff @(posedge clk) begin
        if (capture)
            act_buf <= requant;
    end

endmodule

// File: tb/tb_fc_act_serializer.sv
// Randomized bench for fc_act_serializer with a queue-based reference model
// and directed literal checks for the headline scenarios.
module tb_fc_act_serializer;

    localparam int NN = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic signed [31:0] in_data [NN];
    logic in_ready;
    logic out_valid;
    logic out_ready = 1'b0;
    logic signed [15:0] out_data;
    logic out_last;
    logic drop;

    int vectors = 0;
    int miscompares = 0;

    int exp_q[$];
    bit drop_exp = 1'b0;
    bit m_rdy, m_xfer;

    fc_act_serializer #(
        .NUM_NEURONS(NN),
        .DATA_WIDTH (16),
        .ACC_WIDTH  (32),
        .SHIFT      (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last),
        .drop     (drop)
    );

    always #5 clk = ~clk;

    // Reference requantization: floor(acc / 256), clipped to [0, 32767].
    function automatic int model_act(longint a);
        longint q;
        if (a < 0) return 0;
        q = a / 256;
        if (q > 32767) return 32767;
        return int'(q);
    endfunction

    task automatic check(input string nm, input longint act, input longint req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, req);
        end
    endtask

    // Model: queue holds the not-yet-transferred elements of the current frame.
    always @(posedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            drop_exp = 1'b0;
        end else begin
            m_rdy  = (exp_q.size() == 0) || (out_ready && exp_q.size() == 1);
            m_xfer = (exp_q.size() != 0) && out_ready;
            drop_exp = in_valid && !m_rdy;
            if (m_xfer) void'(exp_q.pop_front());
            if (in_valid && m_rdy)
                for (int i = 0; i < NN; i++)
                    exp_q.push_back(model_act(longint'(in_data[i])));
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("in_ready", in_ready,
                  (exp_q.size() == 0) || (out_ready && exp_q.size() == 1));
            check("out_valid", out_valid, exp_q.size() != 0);
            check("drop", drop, drop_exp);
            if (exp_q.size() != 0) begin
                check("out_data", out_data, exp_q[0]);
                check("out_last", out_last, exp_q.size() == 1);
            end else begin
                check("out_data_idle", out_data, 0);
                check("out_last_idle", out_last, 0);
            end
        end
    end

    task automatic set_frame(input int a0, input int a1, input int a2, input int a3);
        in_data[0] = a0;
        in_data[1] = a1;
        in_data[2] = a2;
        in_data[3] = a3;
    endtask

    // Called at posedge+1; returns at posedge+1 right after capture.
    task automatic pulse_frame();
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic expect_stream(input string nm, input int e0, input int e1,
                                 input int e2, input int e3);
        int e [NN];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        for (int k = 0; k < NN; k++) begin
            @(negedge clk);
            check({nm, "_valid"}, out_valid, 1);
            check({nm, "_data"}, out_data, e[k]);
            check({nm, "_last"}, out_last, k == NN - 1);
        end
        @(negedge clk);
        check({nm, "_done"}, out_valid, 0);
        @(posedge clk); #1;
    endtask

    function automatic int rnd_acc();
        case ($urandom_range(0, 3))
            0: return int'($urandom);
            1: return int'($urandom_range(0, 32'h0000_FFFF));
            2: return int'(32'd8388352 + $urandom_range(0, 1023) - 32'd512);
            default: return -int'($urandom_range(1, 1000));
        endcase
    endfunction

    int xfers;

    initial begin
        set_frame(0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_drop", drop, 0);
        @(posedge clk); #1;

        // Basic frame
        out_ready = 1'b1;
        set_frame(32'h0000_0300, 32'hFFFF_FF00, 32'h0000_0080, 32'h7FFF_FFFF);
        pulse_frame();
        expect_stream("basic", 3, 0, 0, 32767);

        // Rounding and saturation edges
        set_frame(-1, 32'h0000_00FF, 32767 << 8, 32768 << 8);
        pulse_frame();
        expect_stream("edges", 0, 0, 32767, 32767);

        // Backpressure at index 1
        set_frame(32'h0000_0300, 32'hFFFF_FF00, 32'h0000_0080, 32'h7FFF_FFFF);
        pulse_frame();
        xfers = 0;
        @(negedge clk);
        check("bp_first", out_data, 3);
        xfers++;
        @(posedge clk); #1;
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_data", out_data, 0);
            check("bp_hold_last", out_last, 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (out_valid && out_ready) xfers++;
            @(posedge clk); #1;
        end
        check("bp_xfers", xfers, 4);

        // Back-to-back frames
        set_frame(32'h0000_0100, 32'h0000_0200, 32'h0000_0300, 32'h0000_0400);
        pulse_frame();
        repeat (3) @(posedge clk);
        #1;
        set_frame(32'h0000_0A00, 32'h0000_0B00, 32'h0000_0C00, 32'h0000_0D00);
        in_valid = 1'b1;
        @(negedge clk);
        check("b2b_in_ready", in_ready, 1);
        check("b2b_last", out_last, 1);
        check("b2b_data", out_data, 4);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("b2b_new_valid", out_valid, 1);
        check("b2b_new_data", out_data, 10);
        check("b2b_drop", drop, 0);
        repeat (5) @(posedge clk);
        #1;

        // Overrun at index 1
        set_frame(32'h0000_0500, 32'h0000_0600, 32'h0000_0700, 32'h0000_0800);
        pulse_frame();
        @(posedge clk); #1;
        set_frame(32'h0000_6300, 32'h0000_6300, 32'h0000_6300, 32'h0000_6300);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("ovr_drop", drop, 1);
        check("ovr_data", out_data, 7);
        @(negedge clk);
        check("ovr_drop_clear", drop, 0);
        check("ovr_data2", out_data, 8);
        repeat (3) @(posedge clk);
        #1;

        // Async reset at index 2
        set_frame(32'h0000_0100, 32'h0000_0200, 32'h0000_0300, 32'h0000_0400);
        pulse_frame();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_last", out_last, 0);
        check("arst_data", out_data, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("arst_in_ready", in_ready, 1);
        check("arst_no_stale", out_valid, 0);
        @(posedge clk); #1;

        // Random traffic
        repeat (600) begin
            for (int i = 0; i < NN; i++) in_data[i] = rnd_acc();
            in_valid  = ($urandom_range(0, 4) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("drain_idle", out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
